// File: rtl/logic_unit_sched_pkg.sv
// Opcode constants and scheduler state encoding shared by the logic unit scheduler.
package logic_unit_sched_pkg;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOT  = 2'b11;

    typedef enum logic [1:0] {
        SYNC      = 2'b00,
        IDLE      = 2'b01,
        ISSUE     = 2'b10,
        WAIT_DONE = 2'b11
    } sched_state_t;

endpackage

// File: rtl/logic_unit_sched_rr_arbiter.sv
// Combinational round-robin picker: search starts one past i_ptr and wraps modulo N.
// Produces a one-hot grant and the winner index; no grant while i_en is low.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (i_en && !w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/logic_unit_sched.sv
// Round-robin scheduler sharing one multi-cycle logic unit; all outputs registered.
// Nominal: lu_cs one cycle after req, done five cycles after lu_cs; abort with err after TIMEOUT.
module logic_unit_sched
    import logic_unit_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     req_sel,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     err,
    output logic                     lu_cs,
    output logic [1:0]               lu_sel,
    output logic [WIDTH-1:0]         lu_a,
    output logic [WIDTH-1:0]         lu_b,
    input  logic [WIDTH-1:0]         lu_result,
    input  logic                     lu_ready
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t       r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_cs, w_cs_nxt;
    logic [1:0]         r_sel, w_sel_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [PW-1:0]      r_ptr, w_ptr_nxt;
    logic [TW-1:0]      r_timer, w_timer_nxt;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [PW-1:0]      w_arb_idx;
    logic               w_arb_en;
    logic               w_expired;
    logic               w_abort;

    // No grant during the done cycle, so a requester still holding req is seen afresh afterwards.
    assign w_arb_en  = (r_state == IDLE) && (r_done == '0);
    assign w_expired = (r_timer == TW'(TIMEOUT - 1));

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .i_en  (w_arb_en),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_err_nxt    = 1'b0;
        w_result_nxt = '0;
        w_cs_nxt     = r_cs;
        w_sel_nxt    = r_sel;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_ptr_nxt    = r_ptr;
        w_timer_nxt  = r_timer;
        w_abort      = 1'b0;
        unique case (r_state)
            SYNC: begin
                if (lu_ready) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_arb_gnt != '0) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_arb_gnt[i]) begin
                            w_sel_nxt = req_sel[2*i +: 2];
                            w_a_nxt   = req_a[WIDTH*i +: WIDTH];
                            w_b_nxt   = req_b[WIDTH*i +: WIDTH];
                        end
                    end
                    w_grant_nxt = w_arb_gnt;
                    w_ptr_nxt   = w_arb_idx;
                    w_cs_nxt    = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!lu_ready) begin
                    w_cs_nxt    = 1'b0;
                    w_timer_nxt = '0;
                    w_state_nxt = WAIT_DONE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                // lu_result is only trusted on this edge; it floats while the unit is busy.
                if (lu_ready) begin
                    w_result_nxt = lu_result;
                    w_done_nxt   = r_grant;
                    w_grant_nxt  = '0;
                    w_state_nxt  = IDLE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = SYNC;
        endcase
        if (w_abort) begin
            w_done_nxt   = r_grant;
            w_err_nxt    = 1'b1;
            w_result_nxt = '0;
            w_cs_nxt     = 1'b0;
            w_grant_nxt  = '0;
            w_state_nxt  = SYNC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= SYNC;
            r_grant  <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_cs     <= 1'b0;
            r_sel    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ptr    <= PW'(NUM_REQ - 1);
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_result <= w_result_nxt;
            r_cs     <= w_cs_nxt;
            r_sel    <= w_sel_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_ptr    <= w_ptr_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    assign grant      = r_grant;
    assign done       = r_done;
    assign err        = r_err;
    assign rsp_result = r_result;
    assign lu_cs      = r_cs;
    assign lu_sel     = r_sel;
    assign lu_a       = r_a;
    assign lu_b       = r_b;

endmodule

// File: tb/tb_logic_unit_sched.sv
// Bench for logic_unit_sched: behavioural logic unit, RR reference model and scoreboard monitor.
module tb_logic_unit_sched;
    import logic_unit_sched_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] req_sel = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic [N-1:0]   grant, done;
    logic [W-1:0]   rsp_result;
    logic           err, lu_cs;
    logic [1:0]     lu_sel;
    logic [W-1:0]   lu_a, lu_b;
    wire  [W-1:0]   lu_result;
    logic           lu_ready = 1'b0;

    logic_unit_sched #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
        .grant(grant), .done(done), .rsp_result(rsp_result), .err(err),
        .lu_cs(lu_cs), .lu_sel(lu_sel), .lu_a(lu_a), .lu_b(lu_b),
        .lu_result(lu_result), .lu_ready(lu_ready)
    );

    always #5 clk = ~clk;

    // Logic unit: powers up busy, accepts cs while ready, stays busy three cycles, floats when not holding a result.
    logic [W-1:0] lu_res_m = '0;
    logic         lu_drv   = 1'b0;
    int           lu_cnt   = 0;
    int           lu_boot  = 0;
    bit           lu_stuck = 1'b0;
    assign lu_result = lu_drv ? lu_res_m : 'z;

    always @(posedge clk) begin
        if (lu_boot < 3) begin
            lu_boot  <= lu_boot + 1;
            lu_ready <= (lu_boot == 2);
        end else if (lu_stuck) begin
            lu_ready <= 1'b1;
        end else if (lu_cnt == 0) begin
            if (lu_cs && lu_ready) begin
                lu_ready <= 1'b0;
                lu_drv   <= 1'b0;
                lu_cnt   <= 3;
                case (lu_sel)
                    2'b00:   lu_res_m <= ~(lu_a & lu_b);
                    2'b01:   lu_res_m <= ~(lu_a | lu_b);
                    2'b10:   lu_res_m <= lu_a ^ lu_b;
                    default: lu_res_m <= ~lu_a;
                endcase
            end
        end else if (lu_cnt == 1) begin
            lu_ready <= 1'b1;
            lu_drv   <= 1'b1;
            lu_cnt   <= 0;
        end else begin
            lu_cnt <= lu_cnt - 1;
        end
    end

    typedef struct {
        int         idx;
        logic [1:0] sel;
        logic [W-1:0] a, b, res;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   mis_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vec_cnt++;
        if (act !== want) begin
            mis_cnt++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, want, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XOR:  return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Scoreboard monitor
    int       cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] m_prev_grant = '0;
    logic         m_prev_cs    = 1'b0;
    int           m_cs_cyc     = 0;
    int           m_last_gnt   = -100;
    exp_t         m_e;

    always @(negedge clk) begin
        if (grant != '0 && m_prev_grant == '0) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 64'(grant), 64'(0));
            end else begin
                check("grant_order", 64'(grant), 64'(N'(1) << exp_q[0].idx));
                check("grant_with_cs", 64'(lu_cs), 64'(1));
                check("grant_spacing", 64'((cyc - m_last_gnt) >= 7), 64'(1));
                m_last_gnt = cyc;
            end
        end
        if (grant != '0 && exp_q.size() != 0)
            check("operands_held", {lu_sel, lu_a, lu_b}, {exp_q[0].sel, exp_q[0].a, exp_q[0].b});
        if (lu_cs && !m_prev_cs) m_cs_cyc = cyc;
        if (done != '0) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 64'(done), 64'(0));
            end else begin
                m_e = exp_q.pop_front();
                check("done_onehot", 64'(done), 64'(N'(1) << m_e.idx));
                check("done_vs_grant", 64'(done), 64'(m_prev_grant));
                check("result", 64'(rsp_result), 64'(m_e.res));
                check("err", 64'(err), 64'(m_e.err));
                check("done_latency", 64'(cyc - m_cs_cyc), m_e.err ? 64'(TO) : 64'(5));
            end
        end else begin
            check("quiet_outputs", {err, rsp_result}, 64'(0));
        end
        m_prev_grant = grant;
        m_prev_cs    = lu_cs;
    end

    // Requester-side stimulus and round-robin reference model
    int           pend_cnt[N];
    int           op_k[N];
    logic [1:0]   op_sel[N][2];
    logic [W-1:0] op_a[N][2], op_b[N][2], op_res[N][2];
    int           m_ptr = N - 1;

    task automatic set_op(input int i, input int k, input logic [1:0] s,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
        op_sel[i][k] = s; op_a[i][k] = a; op_b[i][k] = b; op_res[i][k] = r;
    endtask

    // Each burst's requests are all visible together, so completion order is plain RR over pending counts.
    task automatic plan_burst();
        int   cnt[N];
        int   k[N];
        int   pick;
        exp_t e;
        for (int i = 0; i < N; i++) begin cnt[i] = pend_cnt[i]; k[i] = 0; end
        for (int g = 0; g < 2*N; g++) begin
            pick = -1;
            for (int s = 1; s <= N && pick < 0; s++)
                if (cnt[(m_ptr + s) % N] > 0) pick = (m_ptr + s) % N;
            if (pick < 0) break;
            e.idx = pick;
            e.sel = op_sel[pick][k[pick]];
            e.a   = op_a[pick][k[pick]];
            e.b   = op_b[pick][k[pick]];
            e.err = lu_stuck;
            e.res = lu_stuck ? '0 : op_res[pick][k[pick]];
            exp_q.push_back(e);
            cnt[pick]--; k[pick]++;
            m_ptr = pick;
        end
    endtask

    task automatic load_op(input int i, input int k);
        req_sel[2*i +: 2] = op_sel[i][k];
        req_a[W*i +: W]   = op_a[i][k];
        req_b[W*i +: W]   = op_b[i][k];
    endtask

    task automatic raise_reqs();
        for (int i = 0; i < N; i++)
            if (pend_cnt[i] > 0) begin op_k[i] = 0; load_op(i, 0); req[i] = 1'b1; end
    endtask

    task automatic wait_burst(input bit mut_a1);
        int left;
        int t;
        int stage;
        left = 1; t = 0; stage = 0;
        while (left > 0 && t < 600) begin
            @(negedge clk); t++;
            if (mut_a1 && stage == 1) begin req_a[W +: W] = 16'hFFFF; stage = 2; end
            if (mut_a1 && stage == 0 && grant[1]) stage = 1;
            for (int i = 0; i < N; i++) begin
                if (done[i] && pend_cnt[i] > 0) begin
                    pend_cnt[i]--; op_k[i]++;
                    if (pend_cnt[i] > 0) load_op(i, op_k[i]);
                    else req[i] = 1'b0;
                end
            end
            left = 0;
            for (int i = 0; i < N; i++) left += pend_cnt[i];
        end
        check("burst_complete", 64'(left), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic run_burst(input bit chk_cs, input bit mut_a1);
        plan_burst();
        raise_reqs();
        if (chk_cs) begin
            @(negedge clk);
            check("cs_latency", 64'(lu_cs), 64'(1));
        end
        wait_burst(mut_a1);
    endtask

    task automatic single(input int i, input logic [1:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] r, input bit mut_a1);
        set_op(i, 0, s, a, b, r);
        pend_cnt[i] = 1;
        run_burst(1'b1, mut_a1);
    endtask

    initial begin
        logic [1:0]   s;
        logic [W-1:0] a, b;
        int           t;
        for (int i = 0; i < N; i++) begin pend_cnt[i] = 0; op_k[i] = 0; end

        #1 rst = 1'b1;
        #2;
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_result", 64'(rsp_result), 64'(0));
        check("rst_cs", 64'(lu_cs), 64'(0));
        check("rst_lu_ops", {lu_sel, lu_a, lu_b}, 64'(0));

        // All four requesting from reset; requester 0 holds req for a second operation.
        for (int i = 0; i < N; i++) begin
            a = 16'($urandom); b = 16'($urandom); s = 2'(i);
            set_op(i, 0, s, a, b, ref_op(s, a, b));
            pend_cnt[i] = 1;
        end
        a = 16'h1357; b = 16'h2468;
        set_op(0, 1, OP_XOR, a, b, ref_op(OP_XOR, a, b));
        pend_cnt[0] = 2;
        plan_burst();
        raise_reqs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_burst(1'b0);

        single(0, OP_NAND, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0);
        single(2, OP_NOR,  16'hAAAA, 16'h5555, 16'h0000, 1'b0);
        single(2, OP_XOR,  16'hAAAA, 16'h5555, 16'hFFFF, 1'b0);
        single(2, OP_NOT,  16'hAAAA, 16'h5555, 16'h5555, 1'b0);
        single(1, OP_XOR,  16'h1234, 16'h0F0F, 16'h1D3B, 1'b1);

        lu_stuck = 1'b1;
        single(3, OP_NAND, 16'h00FF, 16'h0F0F, 16'hFFF0, 1'b0);
        lu_stuck = 1'b0;
        single(0, OP_NOR, 16'h0F00, 16'h00F0, 16'hF00F, 1'b0);

        // Reset while the operation waits on the unit: no done, then normal service.
        set_op(3, 0, OP_XOR, 16'h5A5A, 16'h0FF0, 16'h55AA);
        pend_cnt[3] = 1;
        plan_burst();
        raise_reqs();
        t = 0;
        while (!(grant[3] && !lu_cs) && t < 50) begin @(negedge clk); t++; end
        check("reached_wait_done", 64'(grant[3] && !lu_cs), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_grant", 64'(grant), 64'(0));
        check("arst_done_err", {done, err}, 64'(0));
        check("arst_lu", {lu_cs, lu_sel, lu_a, lu_b}, 64'(0));
        req[3] = 1'b0;
        pend_cnt[3] = 0;
        exp_q.delete();
        m_ptr = N - 1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        single(2, OP_XOR, 16'hC3C3, 16'h0FF0, 16'hCC33, 1'b0);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < N; i++) pend_cnt[i] = 0;
            t = $urandom_range(1, (1 << N) - 1);
            for (int i = 0; i < N; i++) begin
                if (t[i]) begin
                    pend_cnt[i] = $urandom_range(1, 2);
                    for (int k = 0; k < 2; k++) begin
                        s = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom);
                        set_op(i, k, s, a, b, ref_op(s, a, b));
                    end
                end
            end
            run_burst(1'b0, 1'b0);
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
